// File: rtl/obstacle_spawner.sv
// Per-frame obstacle/coin spawn decision with minimum-gap enforcement and a valid/ready hand-off.
// Optional statistics counters are compiled in when SPAWNER_STATS_EN is defined.
module obstacle_spawner #(
  parameter int MIN_GAP      = 24,
  parameter int SPAWN_THRESH = 96,
  parameter int COIN_RUN     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        game_active,
  input  logic [15:0] rand_val,
  output logic        spawn_valid,
  input  logic        spawn_ready,
  output logic [1:0]  spawn_lane,
  output logic [1:0]  spawn_kind,
  output logic [7:0]  gap_cnt
`ifdef SPAWNER_STATS_EN
  ,
  output logic [15:0] obstacles_spawned,
  output logic [15:0] coins_spawned,
  output logic [15:0] ticks_dropped
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    OFFER,
    COIN_WAIT
  } state_t;

  localparam logic [1:0] KIND_NONE    = 2'd0;
  localparam logic [1:0] KIND_BARRIER = 2'd1;
  localparam logic [1:0] KIND_TRAIN   = 2'd2;
  localparam logic [1:0] KIND_COIN    = 2'd3;

  // Threshold is 9 bits wide so that 256 means "always spawn when the gap allows".
  localparam logic [8:0] THRESH      = 9'(SPAWN_THRESH);
  localparam logic [7:0] GAP_MIN     = 8'(MIN_GAP);
  localparam logic [3:0] COIN_RELOAD = 4'(COIN_RUN - 1);

  state_t      state;
  logic [15:0] sample;
  logic [3:0]  coins_left;
  logic        accept;
  logic        accept_obstacle;
  logic        is_obstacle;
  logic [1:0]  decide_lane;
  logic        sample_unused;

  assign accept          = spawn_valid & spawn_ready;
  assign accept_obstacle = accept & (spawn_kind != KIND_COIN);
  assign decide_lane     = (sample[9:8] == 2'd3) ? 2'd1 : sample[9:8];
  assign is_obstacle     = (gap_cnt >= GAP_MIN) && ({1'b0, sample[7:0]} < THRESH);
  assign sample_unused   = ^{sample[15:13], sample[10]};

  // An obstacle acceptance on the same edge as a frame tick leaves the counter at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= 8'd0;
    end else if (accept_obstacle) begin
      gap_cnt <= 8'd0;
    end else if (frame_tick && gap_cnt != 8'hFF) begin
      gap_cnt <= gap_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sample      <= 16'd0;
      coins_left  <= 4'd0;
      spawn_valid <= 1'b0;
      spawn_lane  <= 2'd0;
      spawn_kind  <= KIND_NONE;
    end else if (!game_active) begin
      state       <= IDLE;
      coins_left  <= 4'd0;
      spawn_valid <= 1'b0;
      spawn_lane  <= 2'd0;
      spawn_kind  <= KIND_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            sample <= rand_val;
            state  <= DECIDE;
          end
        end
        DECIDE: begin
          if (is_obstacle) begin
            spawn_lane  <= decide_lane;
            spawn_kind  <= sample[11] ? KIND_TRAIN : KIND_BARRIER;
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end else if (sample[12]) begin
            spawn_lane  <= decide_lane;
            spawn_kind  <= KIND_COIN;
            coins_left  <= COIN_RELOAD;
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end else begin
            state <= IDLE;
          end
        end
        OFFER: begin
          // Lane and kind survive into COIN_WAIT; that is the latched run lane.
          if (accept) begin
            spawn_valid <= 1'b0;
            if (spawn_kind == KIND_COIN && coins_left != 4'd0) begin
              state <= COIN_WAIT;
            end else begin
              state      <= IDLE;
              spawn_lane <= 2'd0;
              spawn_kind <= KIND_NONE;
            end
          end
        end
        COIN_WAIT: begin
          if (frame_tick) begin
            spawn_valid <= 1'b1;
            coins_left  <= coins_left - 4'd1;
            state       <= OFFER;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPAWNER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      obstacles_spawned <= 16'd0;
      coins_spawned     <= 16'd0;
      ticks_dropped     <= 16'd0;
    end else begin
      if (accept_obstacle) obstacles_spawned <= obstacles_spawned + 16'd1;
      if (accept && spawn_kind == KIND_COIN) coins_spawned <= coins_spawned + 16'd1;
      if (frame_tick && (state == DECIDE || state == OFFER)) ticks_dropped <= ticks_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner; stats ports are exercised when SPAWNER_STATS_EN is defined.
module tb_obstacle_spawner;

  localparam int MIN_GAP      = 24;
  localparam int SPAWN_THRESH = 96;
  localparam int COIN_RUN     = 4;

  logic        clock;
  logic        reset;
  logic        frame_tick;
  logic        game_active;
  logic [15:0] rand_val;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [1:0]  spawn_lane;
  logic [1:0]  spawn_kind;
  logic [7:0]  gap_cnt;
`ifdef SPAWNER_STATS_EN
  logic [15:0] obstacles_spawned;
  logic [15:0] coins_spawned;
  logic [15:0] ticks_dropped;
`endif

  obstacle_spawner #(
    .MIN_GAP     (MIN_GAP),
    .SPAWN_THRESH(SPAWN_THRESH),
    .COIN_RUN    (COIN_RUN)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .game_active(game_active),
    .rand_val   (rand_val),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_lane (spawn_lane),
    .spawn_kind (spawn_kind),
    .gap_cnt    (gap_cnt)
`ifdef SPAWNER_STATS_EN
    ,
    .obstacles_spawned(obstacles_spawned),
    .coins_spawned    (coins_spawned),
    .ticks_dropped    (ticks_dropped)
`endif
  );

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] kind;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   gap_model;
  int   coins_model;
  logic [1:0] coin_lane_model;
  int   spurious;
  int   obs_cnt;
  int   coin_cnt;
  int   drop_cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] lane_of(input logic [15:0] r);
    return (r[9:8] == 2'd3) ? 2'd1 : r[9:8];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Predicts the spawn from the spec rules, then pulses one sampled frame tick.
  task automatic applyStimulus(input logic [15:0] r);
    if (gap_model < 255) gap_model++;
    if (coins_model > 0) begin
      sb.push_back('{lane: coin_lane_model, kind: 2'd3});
      coins_model--;
    end else if (gap_model >= MIN_GAP && int'(r[7:0]) < SPAWN_THRESH) begin
      sb.push_back('{lane: lane_of(r), kind: (r[11] ? 2'd2 : 2'd1)});
    end else if (r[12]) begin
      sb.push_back('{lane: lane_of(r), kind: 2'd3});
      coins_model     = COIN_RUN - 1;
      coin_lane_model = lane_of(r);
    end
    rand_val   = r;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic tickIdle(input int n);
    for (int i = 0; i < n; i++) begin
      if (gap_model < 255) gap_model++;
      rand_val   = 16'h00FF;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      spurious += int'(spawn_valid);
      step();
    end
  endtask

  task automatic dropTick();
    if (gap_model < 255) gap_model++;
    drop_cnt++;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic comparePop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_lane"}, 32'(spawn_lane), 32'(e.lane));
      checkOutput({tag, "_kind"}, 32'(spawn_kind), 32'(e.kind));
      if (e.kind == 2'd3) coin_cnt++;
      else obs_cnt++;
    end
  endtask

  task automatic waitTransfer(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      if (spawn_valid && spawn_ready) found = 1'b1;
    end
    if (found) begin
      comparePop(tag);
      step();
    end else begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int bad;
    checks = 0; failures = 0; gap_model = 0; coins_model = 0; coin_lane_model = 2'd0;
    spurious = 0; obs_cnt = 0; coin_cnt = 0; drop_cnt = 0;
    reset = 1'b1; frame_tick = 1'b0; game_active = 1'b0; rand_val = 16'd0; spawn_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("rst_valid", 32'(spawn_valid), 32'd0);
    checkOutput("rst_lane", 32'(spawn_lane), 32'd0);
    checkOutput("rst_kind", 32'(spawn_kind), 32'd0);
    checkOutput("rst_gap", 32'(gap_cnt), 32'd0);

    // Barrier in lane 0 with exact two-edge latency; ready already high.
    game_active = 1'b1;
    spawn_ready = 1'b1;
    tickIdle(30);
    checkOutput("gap_build", 32'(gap_cnt), 32'(gap_model));
    applyStimulus(16'h0005);
    checkOutput("lat_e0_valid", 32'(spawn_valid), 32'd0);
    step();
    checkOutput("lat_e1_valid", 32'(spawn_valid), 32'd1);
    waitTransfer("barrier", 4);
    gap_model = 0;
    checkOutput("barrier_gap_clr", 32'(gap_cnt), 32'd0);
    checkOutput("barrier_valid_drop", 32'(spawn_valid), 32'd0);

    tickIdle(30);
    applyStimulus(16'h0A05);
    waitTransfer("train", 6);
    gap_model = 0;
    tickIdle(30);
    applyStimulus(16'h0305);
    waitTransfer("lane3map", 6);
    gap_model = 0;

    // Backpressure across two dropped frame ticks.
    tickIdle(30);
    spawn_ready = 1'b0;
    applyStimulus(16'h0905);
    step();
    checkOutput("bp_valid", 32'(spawn_valid), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 30) dropTick();
      else step();
      if (!spawn_valid || spawn_lane != sb[0].lane || spawn_kind != sb[0].kind) bad++;
    end
    checkOutput("bp_stable", 32'(bad), 32'd0);
    checkOutput("bp_gap", 32'(gap_cnt), 32'(gap_model));
`ifdef SPAWNER_STATS_EN
    checkOutput("bp_dropped", 32'(ticks_dropped), 32'(drop_cnt));
`endif
    spawn_ready = 1'b1;
    waitTransfer("bp", 3);
    gap_model = 0;
    step();
    step();
    checkOutput("bp_single", 32'(spawn_valid), 32'd0);

    // Acceptance and frame tick on the same edge: gap ends at zero.
    tickIdle(30);
    spawn_ready = 1'b0;
    applyStimulus(16'h0005);
    step();
    spawn_ready = 1'b1;
    frame_tick  = 1'b1;
    drop_cnt++;
    @(negedge clock);
    comparePop("acc_tick");
    step();
    frame_tick = 1'b0;
    gap_model  = 0;
    checkOutput("acc_tick_gap", 32'(gap_cnt), 32'd0);

    // Obstacle-shaped sample below the minimum gap.
    tickIdle(9);
    applyStimulus(16'h0005);
    step();
    checkOutput("gap_short_nospawn", 32'(spawn_valid), 32'd0);
    checkOutput("gap_short_gap", 32'(gap_cnt), 32'd10);

    // Coin run of four in lane 1, then back to sampling.
    applyStimulus(16'h1180);
    waitTransfer("coin0", 6);
    for (int i = 1; i < COIN_RUN; i++) begin
      step();
      applyStimulus(16'h0005);
      waitTransfer("coin_n", 4);
    end
    applyStimulus(16'h00FF);
    step();
    checkOutput("coin_end_nospawn", 32'(spawn_valid), 32'd0);

    tickIdle(300);
    checkOutput("gap_saturate", 32'(gap_cnt), 32'd255);

    // game_active withdrawal during OFFER.
    spawn_ready = 1'b0;
    applyStimulus(16'h0005);
    step();
    checkOutput("ga_valid", 32'(spawn_valid), 32'd1);
    game_active = 1'b0;
    step();
    checkOutput("ga_drop_valid", 32'(spawn_valid), 32'd0);
    checkOutput("ga_drop_kind", 32'(spawn_kind), 32'd0);
    checkOutput("ga_gap_held", 32'(gap_cnt), 32'(gap_model));
    void'(sb.pop_front());
    game_active = 1'b1;
    spawn_ready = 1'b1;
    step();
    applyStimulus(16'h0A05);
    waitTransfer("ga_resume", 6);
    gap_model = 0;

`ifdef SPAWNER_STATS_EN
    checkOutput("stat_obstacles", 32'(obstacles_spawned), 32'(obs_cnt));
    checkOutput("stat_coins", 32'(coins_spawned), 32'(coin_cnt));
    checkOutput("stat_dropped", 32'(ticks_dropped), 32'(drop_cnt));
`endif

    // Asynchronous reset in the middle of an offer.
    tickIdle(30);
    spawn_ready = 1'b0;
    applyStimulus(16'h0005);
    step();
    checkOutput("rst_offer_valid", 32'(spawn_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid", 32'(spawn_valid), 32'd0);
    checkOutput("rst_async_lane", 32'(spawn_lane), 32'd0);
    checkOutput("rst_async_kind", 32'(spawn_kind), 32'd0);
    checkOutput("rst_async_gap", 32'(gap_cnt), 32'd0);
    void'(sb.pop_front());
    step();
    reset = 1'b0;
    gap_model = 0;
    step();

    checkOutput("no_spurious", 32'(spurious), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] obstacles=%0d coins=%0d dropped=%0d", obs_cnt, coin_cnt, drop_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
